// File: rtl/operand_multicast_queue_pkg.sv
// operand_multicast_queue_pkg: command type and sizing limits shared by the multicast operand queue.
// Rev 1.0
`default_nettype none

package operand_multicast_queue_pkg;

    localparam int unsigned MaxMcastConsumers = 8;
    localparam int unsigned MaxMcastBeats     = 256;
    localparam int unsigned MaxMcastBeatW     = $clog2(MaxMcastBeats + 1);

    typedef struct packed {
        logic [MaxMcastBeatW-1:0]     beats;
        logic [MaxMcastConsumers-1:0] dest_mask;
    } mcast_cmd_t;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/operand_multicast_queue_fifo.sv
// operand_multicast_queue_fifo: registered (non fall-through) FIFO; push while full is dropped.
// Rev 1.0
`default_nettype none

module operand_multicast_queue_fifo
    import operand_multicast_queue_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = addr_width(Depth);
    localparam int unsigned CntW  = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == AddrW'(Depth - 1)) ? '0 : wr_ptr_q + AddrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AddrW'(Depth - 1)) ? '0 : rd_ptr_q + AddrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the occupancy count already marks it empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/operand_multicast_queue.sv
// operand_multicast_queue: buffers VRF read beats and multicasts each one to a subset of consumer FUs,
// with per-command beat counting and credit flow control toward the operand requester. Rev 1.0
`default_nettype none

module operand_multicast_queue
    import operand_multicast_queue_pkg::*;
#(
    parameter int unsigned NrConsumers  = 2,
    parameter int unsigned DataBufDepth = 4,
    parameter int unsigned CmdBufDepth  = 4,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned MaxBeats     = 256
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  mcast_cmd_t                       cmd_i,
    input  logic                             cmd_valid_i,
    output logic                             cmd_ready_o,
    input  logic [DataWidth-1:0]             operand_i,
    input  logic                             operand_valid_i,
    input  logic                             operand_issued_i,
    output logic                             operand_queue_ready_o,
    output logic [NrConsumers*DataWidth-1:0] operand_o,
    output logic [NrConsumers-1:0]           operand_valid_o,
    input  logic [NrConsumers-1:0]           operand_ready_i,
    output logic                             cmd_done_o
);

    localparam int unsigned BeatW = $clog2(MaxBeats + 1);
    localparam int unsigned CredW = $clog2(DataBufDepth + 1);

    if (NrConsumers > MaxMcastConsumers || MaxBeats > MaxMcastBeats) begin : g_param_check
        $error("operand_multicast_queue: parameters exceed package limits");
    end

    mcast_cmd_t             head_cmd;
    logic                   cmd_full, cmd_empty, cmd_push, cmd_pop;
    logic [DataWidth-1:0]   head_data;
    logic                   data_full, data_empty;
    logic [NrConsumers-1:0] mask, accept;
    logic [NrConsumers-1:0] sent_q, sent_d;
    logic [BeatW-1:0]       beats, beat_cnt_q, beat_cnt_d;
    logic [CredW-1:0]       credits_q, credits_d;
    logic                   done_q;
    logic                   head_ok, beat_pop, last_beat, zero_cmd, issue_ok;
    logic                   head_unused;

    assign cmd_push = cmd_valid_i & ~cmd_full;

    operand_multicast_queue_fifo #(
        .Depth (CmdBufDepth),
        .Width ($bits(mcast_cmd_t))
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_push),
        .data_i  (cmd_i),
        .pop_i   (cmd_pop),
        .data_o  (head_cmd),
        .full_o  (cmd_full),
        .empty_o (cmd_empty)
    );

    operand_multicast_queue_fifo #(
        .Depth (DataBufDepth),
        .Width (DataWidth)
    ) u_data_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (operand_valid_i),
        .data_i  (operand_i),
        .pop_i   (beat_pop),
        .data_o  (head_data),
        .full_o  (data_full),
        .empty_o (data_empty)
    );

    // Upper mask/beat bits beyond this instance's sizing are intentionally ignored.
    assign head_unused = ^head_cmd;
    assign mask        = head_cmd.dest_mask[NrConsumers-1:0];
    assign beats       = head_cmd.beats[BeatW-1:0];

    assign head_ok         = ~data_empty & ~cmd_empty & (beats != '0);
    assign operand_valid_o = {NrConsumers{head_ok}} & mask & ~sent_q;
    assign accept          = operand_valid_o & operand_ready_i;
    // A beat retires once every addressed consumer has taken it, possibly over several cycles.
    assign beat_pop        = head_ok & (((sent_q | accept) & mask) == mask);
    assign last_beat       = (beat_cnt_q == beats - BeatW'(1));
    assign zero_cmd        = ~cmd_empty & (beats == '0);
    assign cmd_pop         = zero_cmd | (beat_pop & last_beat);

    assign operand_queue_ready_o = (credits_q != '0);
    assign issue_ok              = operand_issued_i & operand_queue_ready_o;
    assign cmd_ready_o           = ~cmd_full;
    assign cmd_done_o            = done_q;

    for (genvar c = 0; c < NrConsumers; c++) begin : g_lane
        assign operand_o[c*DataWidth +: DataWidth] = data_empty ? '0 : head_data;
    end

    always_comb begin
        sent_d     = sent_q | accept;
        beat_cnt_d = beat_cnt_q;
        credits_d  = credits_q;
        if (beat_pop) begin
            sent_d     = '0;
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + BeatW'(1);
        end
        case ({beat_pop, issue_ok})
            2'b10:   credits_d = credits_q + CredW'(1);
            2'b01:   credits_d = credits_q - CredW'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sent_q     <= '0;
            beat_cnt_q <= '0;
            credits_q  <= CredW'(DataBufDepth);
            done_q     <= 1'b0;
        end else begin
            sent_q     <= sent_d;
            beat_cnt_q <= beat_cnt_d;
            credits_q  <= credits_d;
            done_q     <= cmd_pop;
        end
    end

`ifndef SYNTHESIS
    a_no_data_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(operand_valid_i && data_full))
        else $error("operand written while data buffer full");
    a_credit_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        credits_q <= CredW'(DataBufDepth))
        else $error("credit counter above buffer depth");
    a_no_issue_at_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(operand_issued_i && credits_q == '0))
        else $error("operand issued with no credits");
`endif

endmodule

`default_nettype wire
